// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer. It drives an external 1-bit full adder LSB first,
// keeps the carry in a register between bits, and assembles the sum and final carry.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum_out;
    logic [WIDTH-1:0] w_sum_next;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_run;

    assign w_run    = (r_state == RUN);
    assign w_accept = (r_state == IDLE) && start && !abort;
    assign w_last   = (r_cnt == LAST_BIT);

    // A 1-bit sum has no older bits to shift along, so it is just this cycle's fa_s.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = fa_s;
        end else begin : g_sum_wn
            assign w_sum_next = {fa_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. The unused encoding falls back to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = RUN;
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Status flags and full-adder operands, all decoded from the state.
    always_comb begin
        busy   = (r_state == RUN) || (r_state == DONE);
        done   = (r_state == DONE);
        fa_a   = w_run & r_a_sh[0];
        fa_b   = w_run & r_b_sh[0];
        fa_cin = w_run & r_carry;
    end

    // Operand latching, bit-serial shifting and result capture.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_sum_out <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run && !abort) begin
            r_sum_sh <= w_sum_next;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= fa_cout;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum_out <= w_sum_next;
                r_cout    <= fa_cout;
            end
        end
    end

    assign sum_out  = r_sum_out;
    assign cout_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 main instance plus WIDTH=1 and WIDTH=16 builds.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       RST, start, abort, cin;
    logic [7:0] a_in, b_in, sum_out;
    logic       fa_s, fa_cout, fa_a, fa_b, fa_cin, busy, done, cout_out;

    logic        x1_start, x1_cin, x1_fa_s, x1_fa_cout, x1_fa_a, x1_fa_b, x1_fa_cin;
    logic        x1_busy, x1_done, x1_cout;
    logic [0:0]  x1_a, x1_b, x1_sum;
    logic        x16_start, x16_cin, x16_fa_s, x16_fa_cout, x16_fa_a, x16_fa_b, x16_fa_cin;
    logic        x16_busy, x16_done, x16_cout;
    logic [15:0] x16_a, x16_b, x16_sum;
    logic        aux_abort;

    // Bench models of the external full adder.
    assign fa_s        = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout     = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign x1_fa_s     = x1_fa_a ^ x1_fa_b ^ x1_fa_cin;
    assign x1_fa_cout  = (x1_fa_a & x1_fa_b) | (x1_fa_a & x1_fa_cin) | (x1_fa_b & x1_fa_cin);
    assign x16_fa_s    = x16_fa_a ^ x16_fa_b ^ x16_fa_cin;
    assign x16_fa_cout = (x16_fa_a & x16_fa_b) | (x16_fa_a & x16_fa_cin) | (x16_fa_b & x16_fa_cin);

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .RST(RST), .start(start), .abort(abort), .cin(cin),
        .a_in(a_in), .b_in(b_in), .fa_s(fa_s), .fa_cout(fa_cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .busy(busy), .done(done),
        .sum_out(sum_out), .cout_out(cout_out)
    );

    serial_add_ctrl #(.WIDTH(1)) dut_w1 (
        .clk(clk), .RST(RST), .start(x1_start), .abort(aux_abort), .cin(x1_cin),
        .a_in(x1_a), .b_in(x1_b), .fa_s(x1_fa_s), .fa_cout(x1_fa_cout),
        .fa_a(x1_fa_a), .fa_b(x1_fa_b), .fa_cin(x1_fa_cin), .busy(x1_busy), .done(x1_done),
        .sum_out(x1_sum), .cout_out(x1_cout)
    );

    serial_add_ctrl #(.WIDTH(16)) dut_w16 (
        .clk(clk), .RST(RST), .start(x16_start), .abort(aux_abort), .cin(x16_cin),
        .a_in(x16_a), .b_in(x16_b), .fa_s(x16_fa_s), .fa_cout(x16_fa_cout),
        .fa_a(x16_fa_a), .fa_b(x16_fa_b), .fa_cin(x16_fa_cin), .busy(x16_busy), .done(x16_done),
        .sum_out(x16_sum), .cout_out(x16_cout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: expected {cout, sum} per accepted operation.
    logic [32:0] q_main[$];
    logic [32:0] q1[$];
    logic [32:0] q16[$];

    // Result monitors: pop and compare whenever a done pulse is presented.
    always @(negedge clk) begin
        logic [32:0] e;
        if (done === 1'b1) begin
            if (q_main.size() == 0) check("main_unexpected_done", 64'(done), 64'(0));
            else begin
                e = q_main.pop_front();
                check("main_result", 64'({cout_out, sum_out}), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (x1_done === 1'b1) begin
            if (q1.size() == 0) check("w1_unexpected_done", 64'(x1_done), 64'(0));
            else begin
                e = q1.pop_front();
                check("w1_result", 64'({x1_cout, x1_sum}), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (x16_done === 1'b1) begin
            if (q16.size() == 0) check("w16_unexpected_done", 64'(x16_done), 64'(0));
            else begin
                e = q16.pop_front();
                check("w16_result", 64'({x16_cout, x16_sum}), 64'(e));
            end
        end
    end

    // Datapath protocol monitor for the main instance: fa_* must follow the latched
    // operand bits and the running carry during RUN, and be 0 otherwise.
    logic [7:0] m_a, m_b;
    logic       m_c;
    int         m_i;
    bit         m_active = 1'b0;

    always @(negedge clk) begin
        if (m_active) begin
            check("fa_a_bit", 64'(fa_a), 64'(m_a[m_i]));
            check("fa_b_bit", 64'(fa_b), 64'(m_b[m_i]));
            check("fa_cin_bit", 64'(fa_cin), 64'(m_c));
            m_c = (m_a[m_i] & m_b[m_i]) | (m_a[m_i] & m_c) | (m_b[m_i] & m_c);
            m_i++;
            if (m_i == 8) m_active = 1'b0;
        end else if (RST === 1'b0) begin
            check("fa_idle_zero", 64'({fa_a, fa_b, fa_cin}), 64'(0));
        end
    end

    task automatic arm_model(input logic [7:0] a, input logic [7:0] b, input logic c);
        m_a = a; m_b = b; m_c = c; m_i = 0; m_active = 1'b1;
    endtask

    // Issue start and confirm acceptance at the next edge.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        arm_model(a, b, c);
        check("accept_busy", 64'(busy), 64'(1));
    endtask

    // Wait (bounded) for done; busy must hold for every cycle until then.
    task automatic wait_done(input bit hold);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (!hold) begin
                start = 1'b0;
                a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
            end
            if (done === 1'b1) break;
            check("busy_in_run", 64'(busy), 64'(1));
        end
        check("done_latency", 64'(n), 64'(9));
        check("busy_in_done", 64'(busy), 64'(1));
    endtask

    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] exp);
        q_main.push_back(33'(exp));
        accept(a, b, c);
        wait_done(1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] s;
    } vec_t;

    vec_t vecs[5] = '{
        '{8'h5A, 8'h3C, 1'b0, 9'h096},
        '{8'hFF, 8'h01, 1'b0, 9'h100},
        '{8'hFF, 8'h00, 1'b1, 9'h100},
        '{8'h00, 8'h00, 1'b1, 9'h001},
        '{8'h12, 8'h34, 1'b0, 9'h046}
    };

    task automatic run_w1(input logic a, input logic b, input logic c);
        int n;
        q1.push_back(33'(2'(a) + 2'(b) + 2'(c)));
        @(negedge clk);
        x1_a = a; x1_b = b; x1_cin = c; x1_start = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            x1_start = 1'b0;
            if (x1_done === 1'b1) break;
        end
        check("w1_latency", 64'(n), 64'(2));
    endtask

    task automatic run_w16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        q16.push_back(33'(17'(a) + 17'(b) + 17'(c)));
        @(negedge clk);
        x16_a = a; x16_b = b; x16_cin = c; x16_start = 1'b1;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            x16_start = 1'b0;
            if (x16_done === 1'b1) break;
        end
        check("w16_latency", 64'(n), 64'(17));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; start = 1'b0; abort = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
        x1_start = 1'b0; x1_cin = 1'b0; x1_a = '0; x1_b = '0;
        x16_start = 1'b0; x16_cin = 1'b0; x16_a = '0; x16_b = '0; aux_abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_result", 64'({cout_out, sum_out}), 64'(0));
        RST = 1'b0;

        // Directed additions, including carry and wrap-around cases.
        foreach (vecs[i]) do_add(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);

        // Abort on the 4th RUN cycle: no done, previous result kept.
        accept(8'hAA, 8'h55, 1'b0);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        m_active = 1'b0;
        check("abort_to_idle", 64'(busy), 64'(0));
        @(negedge clk);
        abort = 1'b0;
        check("abort_no_done", 64'(done), 64'(0));
        check("abort_keeps_result", 64'({cout_out, sum_out}), 64'(9'h046));
        do_add(8'h01, 8'h01, 1'b0, 9'h002);

        // start together with abort in IDLE is not accepted.
        @(negedge clk);
        a_in = 8'h77; b_in = 8'h11; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("start_abort_rejected", 64'(busy), 64'(0));
        @(negedge clk);
        start = 1'b0; abort = 1'b0;

        // start held through the busy window: re-accepted two edges after done.
        q_main.push_back(33'(9'h030));
        accept(8'h10, 8'h20, 1'b0);
        a_in = 8'hFF;
        wait_done(1'b1);
        q_main.push_back(33'(9'h11F));
        @(posedge clk); #1;
        check("hold_idle_gap", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("hold_reaccept", 64'(busy), 64'(1));
        arm_model(8'hFF, 8'h20, 1'b0);
        wait_done(1'b0);

        // Asynchronous reset between edges in the middle of RUN.
        accept(8'hAA, 8'h55, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        RST = 1'b1;
        #1;
        m_active = 1'b0;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_done", 64'(done), 64'(0));
        check("async_rst_result", 64'({cout_out, sum_out}), 64'(0));
        @(negedge clk);
        RST = 1'b0;
        do_add(8'h80, 8'h80, 1'b1, 9'h101);

        // WIDTH=1 build: every operand combination.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            run_w1(bits[2], bits[1], bits[0]);
        end

        // WIDTH=16 build: boundary plus random operands.
        run_w16(16'hFFFF, 16'h0001, 1'b0);
        run_w16(16'hFFFF, 16'hFFFF, 1'b1);
        for (int v = 0; v < 6; v++) begin
            run_w16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q_main.size() + q1.size() + q16.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for the team's 1-bit full-adder datapath; performs WIDTH-bit additions bit-serially, LSB first.
- Latches two operands and a carry-in on a start request.
- Drives the external combinational full adder one bit per cycle and keeps the carry in a register between bits.
- Assembles the sum and final carry, then reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising edge.
RST  input  1  reset; asynchronous and active-high.
start  input  1  request; sampled only in IDLE.
abort  input  1  cancel an operation in progress; sampled only in RUN.
cin  input  1  carry-in for the addition, latched with the operands.
a_in  input  WIDTH  operand A, latched on accepted start.
b_in  input  WIDTH  operand B, latched on accepted start.
fa_s  input  1  sum bit returned by the external full adder.
fa_cout  input  1  carry bit returned by the external full adder.
fa_a  output  1  A bit to the full adder.
fa_b  output  1  B bit to the full adder.
fa_cin  output  1  carry to the full adder.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle completion pulse.
sum_out  output  WIDTH  result of the last completed addition.
cout_out  output  1  final carry of the last completed addition.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- RST=1 forces, immediately and asynchronously:
  - state=IDLE;
  - busy=0, done=0, sum_out=0, cout_out=0;
  - shift registers, carry register and bit counter to 0.
- States: IDLE, RUN, DONE. Encode as 2 bits; the unused code returns to IDLE on the next edge.
- IDLE:
  - On start=1 and abort=0: latch a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0; go to RUN.
  - start=1 together with abort=1: not accepted; stay in IDLE.
- RUN, combinational outputs: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
- RUN, each edge with abort=0:
  - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
  - a_sh and b_sh shift right by 1, zero-filled;
  - carry <= fa_cout; cnt <= cnt+1.
- RUN exit: when cnt==WIDTH-1 at the edge, the last bit is captured and the next state is DONE.
  - sum_out <= final assembled sum, including this edge's fa_s.
  - cout_out <= fa_cout.
- RUN with abort=1: next edge goes to IDLE.
  - No bit is captured; sum_out and cout_out keep their previous values; done does not pulse.
- DONE: done=1 for exactly this one cycle; unconditionally go to IDLE on the next edge. start in DONE is ignored.
- fa_a, fa_b and fa_cin are 0 outside RUN.
- busy is decoded from state: 1 in RUN and DONE, 0 in IDLE.
- done is decoded from state (DONE only).
- Timing: start accepted at edge E0 → RUN occupies edges E1..E(WIDTH) → DONE is the cycle after E(WIDTH), so done is seen WIDTH+1 edges after start.
  - Back-to-back throughput is one addition per WIDTH+2 cycles.
- Start and abort handling:
  - start while busy is ignored; no queuing.
  - abort is ignored in IDLE and DONE.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1); no overflow flag beyond cout_out.
- Operand inputs may change freely after the accepting edge.
- WIDTH=1: RUN lasts exactly one edge.
- Counter width is max(1, $clog2(WIDTH)).
- Reset asserted mid-RUN: the operation is dropped, no done pulse, and the outputs clear to 0.

Test Plan:
- Basic addition: WIDTH=8, a_in=0x5A, b_in=0x3C, cin=0, pulse start.
  → busy high for 9 cycles; done pulses on the 9th edge after start; sum_out=0x96, cout_out=0.
- Carry and wrap-around: a_in=0xFF, b_in=0x01, cin=0 → sum_out=0x00, cout_out=1.
  - Then a_in=0xFF, b_in=0x00, cin=1 → sum_out=0x00, cout_out=1.
  - Then a_in=0x00, b_in=0x00, cin=1 → sum_out=0x01, cout_out=0.
- Abort mid-operation: complete 0x12+0x34 (sum_out=0x46), then start 0xAA+0x55 and assert abort on the 4th RUN cycle.
  → IDLE next edge, no done pulse, sum_out stays 0x46; a following start with a_in=0x01, b_in=0x01 gives 0x02.
- Start while busy: start 0x10+0x20, hold start=1 continuously with a_in=0xFF.
  → first result 0x30; a new operation is accepted only in IDLE, i.e. 2 cycles after the done edge ends the busy window; that operation returns 0xFF+b_in.
- Asynchronous reset: assert RST between clock edges mid-RUN.
  → state IDLE, busy=0, done=0, sum_out=0x00, cout_out=0 without waiting for a clock edge; normal operation resumes after release.
- Datapath protocol check: a bench model of the full adder compares fa_a, fa_b and fa_cin each RUN cycle against a_in[i], b_in[i] and the running carry.
  - Verify fa_* are 0 in IDLE and DONE.
  - Run WIDTH=1 and WIDTH=16 builds against a random-operand reference sum.
